// File: rtl/smi_rx_sched.sv
// Round-robin sequencer that drains two 32-bit RX FIFOs (0.9 GHz / 2.4 GHz)
// and presents each word to the SMI bus one byte at a time, LSB first.
module smi_rx_sched #(
  parameter int BURST_LEN   = 4,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic [1:0]  i_chan_en,
  output logic        o_fifo_09_pull,
  input  logic [31:0] i_fifo_09_pulled_data,
  input  logic        i_fifo_09_empty,
  output logic        o_fifo_24_pull,
  input  logic [31:0] i_fifo_24_pulled_data,
  input  logic        i_fifo_24_empty,
  input  logic        i_smi_soe_se,
  output logic [7:0]  o_smi_data_out,
  output logic        o_smi_read_req,
  output logic        o_smi_chan,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, PULL, LOAD, TX} state_t;

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic             last_served, last_nxt;
  logic [31:0]      word_buf, buf_nxt;
  logic [1:0]       byte_idx, idx_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic             chan_q, chan_nxt;

  logic [SYNC_STAGES-1:0] soe_sync;
  logic                   soe_prev;
  logic                   read_done;

  logic [1:0] req;
  logic       grant_req, other_req, grant_empty;

  assign req         = i_chan_en & ~{i_fifo_24_empty, i_fifo_09_empty};
  assign grant_req   = req[grant];
  assign other_req   = req[!grant];
  assign grant_empty = grant ? i_fifo_24_empty : i_fifo_09_empty;

  // The SMI strobe is asynchronous; a read completes on its synchronized
  // rising edge (strobe released), detected against one extra history flop.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      soe_sync <= '0;
      soe_prev <= 1'b0;
    end else begin
      soe_sync <= {soe_sync[SYNC_STAGES-2:0], i_smi_soe_se};
      soe_prev <= soe_sync[SYNC_STAGES-1];
    end
  end

  assign read_done = soe_sync[SYNC_STAGES-1] & ~soe_prev;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_nxt       = last_served;
    buf_nxt        = word_buf;
    idx_nxt        = byte_idx;
    cnt_nxt        = burst_cnt;
    chan_nxt       = chan_q;
    o_fifo_09_pull = 1'b0;
    o_fifo_24_pull = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          // With both requesting, the channel not served last wins.
          grant_nxt = (req == 2'b11) ? ~last_served : req[1];
          cnt_nxt   = '0;
          state_nxt = PULL;
        end
      end
      PULL: begin
        if (grant_empty) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          o_fifo_09_pull = ~grant;
          o_fifo_24_pull = grant;
          state_nxt      = LOAD;
        end
      end
      LOAD: begin
        buf_nxt   = grant ? i_fifo_24_pulled_data : i_fifo_09_pulled_data;
        idx_nxt   = 2'd0;
        chan_nxt  = grant;
        last_nxt  = grant;
        state_nxt = TX;
        // Saturates so a long uncontested burst cannot wrap below the limit.
        if (burst_cnt != BURST_MAX) cnt_nxt = burst_cnt + 1'b1;
      end
      TX: begin
        if (read_done) begin
          if (byte_idx == 2'd3) begin
            if (grant_req && (burst_cnt < BURST_MAX || !other_req)) begin
              state_nxt = PULL;
            end else begin
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end
          end else begin
            idx_nxt = byte_idx + 2'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_served <= 1'b1;
      word_buf    <= '0;
      byte_idx    <= '0;
      burst_cnt   <= '0;
      chan_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_served <= last_nxt;
      word_buf    <= buf_nxt;
      byte_idx    <= idx_nxt;
      burst_cnt   <= cnt_nxt;
      chan_q      <= chan_nxt;
    end
  end

  assign o_busy         = (state != IDLE);
  assign o_smi_read_req = (state == TX);
  assign o_smi_chan     = chan_q;
  assign o_smi_data_out = (state == TX) ? word_buf[{byte_idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_smi_rx_sched.sv
// Randomized bench for smi_rx_sched: FIFO models, an SMI reader, and a
// scoreboard fed by a round-robin burst model computed from queue contents.
module tb_smi_rx_sched;

  localparam int BURST_LEN   = 4;
  localparam int SYNC_STAGES = 2;

  logic        i_sys_clk = 1'b0;
  logic        i_rst_b   = 1'b0;
  logic [1:0]  i_chan_en = 2'b00;
  logic        o_fifo_09_pull, o_fifo_24_pull;
  logic [31:0] data09 = '0, data24 = '0;
  logic        i_fifo_09_empty, i_fifo_24_empty;
  logic        i_smi_soe_se = 1'b1;
  logic [7:0]  o_smi_data_out;
  logic        o_smi_read_req, o_smi_chan, o_busy;

  smi_rx_sched #(.BURST_LEN(BURST_LEN), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_sys_clk             (i_sys_clk),
    .i_rst_b               (i_rst_b),
    .i_chan_en             (i_chan_en),
    .o_fifo_09_pull        (o_fifo_09_pull),
    .i_fifo_09_pulled_data (data09),
    .i_fifo_09_empty       (i_fifo_09_empty),
    .o_fifo_24_pull        (o_fifo_24_pull),
    .i_fifo_24_pulled_data (data24),
    .i_fifo_24_empty       (i_fifo_24_empty),
    .i_smi_soe_se          (i_smi_soe_se),
    .o_smi_data_out        (o_smi_data_out),
    .o_smi_read_req        (o_smi_read_req),
    .o_smi_chan            (o_smi_chan),
    .o_busy                (o_busy)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  // FIFO models: word available the cycle after a pull.
  logic [31:0] mem09 [512];
  logic [31:0] mem24 [512];
  logic [8:0]  wr09 = '0, rd09 = '0, wr24 = '0, rd24 = '0;

  assign i_fifo_09_empty = (rd09 == wr09);
  assign i_fifo_24_empty = (rd24 == wr24);

  always @(posedge i_sys_clk) begin
    if (o_fifo_09_pull) begin
      data09 <= mem09[rd09];
      rd09   <= rd09 + 9'd1;
    end
    if (o_fifo_24_pull) begin
      data24 <= mem24[rd24];
      rd24   <= rd24 + 9'd1;
    end
  end

  // Monitor
  int n_pull09 = 0, n_pull24 = 0, low_run = 0;
  bit dbl_pull = 1'b0, any_busy = 1'b0;
  int gaps[$];

  always @(negedge i_sys_clk) begin
    if (o_fifo_09_pull) n_pull09++;
    if (o_fifo_24_pull) n_pull24++;
    if (o_fifo_09_pull && o_fifo_24_pull) dbl_pull = 1'b1;
    if (o_busy) any_busy = 1'b1;
    if (!o_smi_read_req) low_run++;
    else begin
      if (low_run > 0) gaps.push_back(low_run);
      low_run = 0;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending words per channel, served in round-robin bursts.
  logic [31:0] m09[$], m24[$];
  logic [32:0] exp_q[$];
  int          model_last = 1;

  task automatic push09(input logic [31:0] w, input bit to_model);
    mem09[wr09] = w;
    wr09 = wr09 + 9'd1;
    if (to_model) m09.push_back(w);
  endtask

  task automatic push24(input logic [31:0] w, input bit to_model);
    mem24[wr24] = w;
    wr24 = wr24 + 9'd1;
    if (to_model) m24.push_back(w);
  endtask

  task automatic build_expected();
    int cur, cnt, mine, other;
    logic [31:0] w;
    while (m09.size() > 0 || m24.size() > 0) begin
      if (m09.size() > 0 && m24.size() > 0) cur = 1 - model_last;
      else cur = (m09.size() > 0) ? 0 : 1;
      cnt = 0;
      do begin
        if (cur == 0) w = m09.pop_front();
        else          w = m24.pop_front();
        exp_q.push_back({cur[0], w});
        cnt++;
        mine  = (cur == 0) ? m09.size() : m24.size();
        other = (cur == 0) ? m24.size() : m09.size();
      end while (mine > 0 && (cnt < BURST_LEN || other == 0));
      model_last = cur;
    end
  endtask

  task automatic read_byte(output logic [7:0] b, output logic ch);
    bit ok = 1'b0;
    b  = 8'h00;
    ch = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (o_smi_read_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_sys_clk);
    end
    if (!ok) begin
      check("read_req_timeout", 32'd0, 32'd1);
      return;
    end
    b  = o_smi_data_out;
    ch = o_smi_chan;
    i_smi_soe_se = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge i_sys_clk);
    i_smi_soe_se = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge i_sys_clk);
  endtask

  task automatic serve_byte(input string tag, input int k, input logic ch_exp, input logic [31:0] w);
    logic [7:0] b;
    logic       ch;
    read_byte(b, ch);
    check($sformatf("%s_byte%0d", tag, k), {24'd0, b}, {24'd0, w[k*8 +: 8]});
    check($sformatf("%s_chan%0d", tag, k), {31'd0, ch}, {31'd0, ch_exp});
  endtask

  task automatic run_expected(input string tag);
    logic [32:0] e;
    int n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 4; k++) serve_byte($sformatf("%s_w%0d", tag, n), k, e[32], e[31:0]);
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!o_busy) break;
      @(negedge i_sys_clk);
    end
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_read_req"}, {31'd0, o_smi_read_req}, 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_read_req"}, {31'd0, o_smi_read_req}, 32'd0);
    check({tag, "_data"}, {24'd0, o_smi_data_out}, 32'd0);
    check({tag, "_chan"}, {31'd0, o_smi_chan}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_pulls"}, {30'd0, o_fifo_24_pull, o_fifo_09_pull}, 32'd0);
  endtask

  initial begin
    int p09, p24;
    logic [31:0] wa, wb;

    // Reset state
    repeat (3) @(negedge i_sys_clk);
    #1 check_reset("reset");
    @(negedge i_sys_clk);
    i_rst_b = 1'b1;
    i_chan_en = 2'b11;

    // Read strobes while idle with both FIFOs empty
    @(posedge i_sys_clk);
    any_busy = 1'b0;
    p09 = n_pull09; p24 = n_pull24;
    @(negedge i_sys_clk);
    for (int i = 0; i < 4; i++) begin
      i_smi_soe_se = 1'b0;
      repeat (2) @(negedge i_sys_clk);
      i_smi_soe_se = 1'b1;
      repeat (3) @(negedge i_sys_clk);
    end
    @(posedge i_sys_clk);
    check("idle_strobe_busy", {31'd0, any_busy}, 32'd0);
    check("idle_strobe_pulls", n_pull09 + n_pull24 - p09 - p24, 32'd0);
    @(negedge i_sys_clk);
    check("idle_strobe_read_req", {31'd0, o_smi_read_req}, 32'd0);

    // Single 0.9 GHz word
    p09 = n_pull09;
    push09(32'h44332211, 1'b1);
    build_expected();
    run_expected("single09");
    wait_idle("single09");
    check("single09_pulls", n_pull09 - p09, 32'd1);

    // Both channels full: bursts of BURST_LEN alternate
    for (int i = 0; i < 6; i++) begin
      push09($urandom, 1'b1);
      push24($urandom, 1'b1);
    end
    build_expected();
    run_expected("both");
    wait_idle("both");

    // 2.4 GHz only, 3 words: back-to-back with 2-cycle bubbles
    p24 = n_pull24;
    @(posedge i_sys_clk);
    gaps.delete();
    low_run = 0;
    @(negedge i_sys_clk);
    for (int i = 0; i < 3; i++) push24($urandom, 1'b1);
    build_expected();
    run_expected("only24");
    wait_idle("only24");
    repeat (5) @(negedge i_sys_clk);
    check("only24_pulls", n_pull24 - p24, 32'd3);
    check("only24_gap_count", gaps.size(), 32'd3);
    if (gaps.size() == 3) begin
      check("only24_gap1", gaps[1], 32'd2);
      check("only24_gap2", gaps[2], 32'd2);
    end

    // Enable dropped mid-word: word completes, no further 0.9 GHz pull
    wa = $urandom;
    p09 = n_pull09;
    push09(wa, 1'b0);
    push09($urandom, 1'b0);
    serve_byte("endrop", 0, 1'b0, wa);
    serve_byte("endrop", 1, 1'b0, wa);
    i_chan_en = 2'b10;
    serve_byte("endrop", 2, 1'b0, wa);
    serve_byte("endrop", 3, 1'b0, wa);
    wait_idle("endrop");
    repeat (10) @(negedge i_sys_clk);
    check("endrop_pulls", n_pull09 - p09, 32'd1);
    check("endrop_still_idle", {31'd0, o_busy}, 32'd0);
    wr09 = rd09;
    i_chan_en = 2'b11;
    model_last = 0;

    // Reset mid-word: 2.4 GHz word abandoned, fresh 0.9 GHz word after release
    wa = $urandom;
    wb = $urandom;
    push24(wa, 1'b0);
    push09(wb, 1'b0);
    serve_byte("rstmid", 0, 1'b1, wa);
    serve_byte("rstmid", 1, 1'b1, wa);
    serve_byte("rstmid", 2, 1'b1, wa);
    i_rst_b = 1'b0;
    #1 check_reset("rstmid_async");
    @(negedge i_sys_clk);
    model_last = 1;
    m09.push_back(wb);
    wr09 = rd09;
    push09(wb, 1'b0);
    @(negedge i_sys_clk);
    i_rst_b = 1'b1;
    #1 check("rstmid_release_pulls", {30'd0, o_fifo_24_pull, o_fifo_09_pull}, 32'd0);
    @(negedge i_sys_clk);
    build_expected();
    run_expected("rstmid_fresh");
    wait_idle("rstmid_fresh");

    // Randomized queue depths on both channels
    for (int it = 0; it < 6; it++) begin
      int n0 = $urandom_range(0, 6);
      int n1 = $urandom_range(0, 6);
      for (int i = 0; i < n0; i++) push09($urandom, 1'b1);
      for (int i = 0; i < n1; i++) push24($urandom, 1'b1);
      build_expected();
      run_expected($sformatf("rand%0d", it));
      wait_idle($sformatf("rand%0d", it));
      repeat ($urandom_range(1, 5)) @(negedge i_sys_clk);
    end

    check("never_double_pull", {31'd0, dbl_pull}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/smi_rx_sched.md
SMI_RX_SCHED -- requirements
Module: smi_rx_sched

Interface
REQ-001 Parameter BURST_LEN, default 4, max words served from one channel before re-arbitration when the other channel is requesting.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for i_smi_soe_se (min 2).
REQ-003 i_sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst_b  in  1  reset, asynchronous, active-low.
REQ-005 i_chan_en  in  2  channel enable; bit0 = 0.9 GHz FIFO, bit1 = 2.4 GHz FIFO.
REQ-006 o_fifo_09_pull  out  1  one-cycle pull strobe to the 0.9 GHz FIFO.
REQ-007 i_fifo_09_pulled_data  in  32  0.9 GHz FIFO word, valid the cycle after a pull.
REQ-008 i_fifo_09_empty  in  1  0.9 GHz FIFO empty.
REQ-009 o_fifo_24_pull, i_fifo_24_pulled_data, i_fifo_24_empty  out/in/in  1/32/1  same as REQ-006..008 for the 2.4 GHz FIFO.
REQ-010 i_smi_soe_se  in  1  SMI read strobe, asynchronous to i_sys_clk, active-low.
REQ-011 o_smi_data_out  out  8  byte presented to SMI.
REQ-012 o_smi_read_req  out  1  high while a byte is available to SMI.
REQ-013 o_smi_chan  out  1  channel of the word being served (0 = 0.9 GHz, 1 = 2.4 GHz).
REQ-014 o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL run a FSM with states IDLE, PULL, LOAD, TX.
REQ-016 A channel is "requesting" when its enable bit is 1 and its empty flag is 0, both sampled in the current cycle.
REQ-017 IDLE: if no channel is requesting, the block SHALL remain in IDLE; otherwise it SHALL grant a requesting channel and move to PULL.
REQ-018 Arbitration SHALL be round-robin: when both channels request, the channel not last served wins; after reset, last-served = 2.4 GHz, so 0.9 GHz wins first.
REQ-019 PULL: the block SHALL assert exactly one pull strobe (granted channel only) for exactly one cycle, then move to LOAD.
REQ-020 LOAD: the block SHALL latch the granted channel's 32-bit pulled_data into the word buffer, clear byte index to 0, increment the burst counter, and move to TX.
REQ-021 TX: o_smi_data_out SHALL equal buffer byte[index], with byte0 = bits [7:0] first and byte3 = bits [31:24] last; o_smi_read_req SHALL be 1.
REQ-022 i_smi_soe_se SHALL pass through SYNC_STAGES flops; a completed read is a synchronized 0->1 edge, acted on once per edge.
REQ-023 On each completed read in TX, byte index SHALL increment; the completed read of byte3 ends the word.
REQ-024 At word end, the block SHALL move to PULL on the same channel if that channel is still requesting and either (burst count < BURST_LEN) or the other channel is not requesting; otherwise it SHALL clear the burst counter and move to IDLE.
REQ-025 The burst counter SHALL clear on grant change; a channel-to-itself re-grant from IDLE SHALL also start a fresh burst.
REQ-026 o_smi_read_req SHALL be 0 in IDLE, PULL and LOAD, including the cycle after byte3 completes; the bubble between words is exactly 2 cycles (PULL, LOAD) when continuing a burst.
REQ-027 A channel whose enable bit drops mid-word SHALL still have its current word completed; the block SHALL then go to IDLE.
REQ-028 Read edges outside TX SHALL be ignored.
REQ-029 Only the sequencer pulls the FIFOs, so empty cannot assert between grant and pull; the block SHALL NOT pull a FIFO whose empty flag is 1 in the PULL cycle, and SHALL return to IDLE without pulling in that case.
REQ-030 o_smi_chan SHALL update in LOAD and hold through TX.

Reset
REQ-031 While i_rst_b = 0, asynchronously: state = IDLE; both pulls = 0; o_smi_read_req = 0; o_smi_data_out = 0x00; o_smi_chan = 0; o_busy = 0; buffer, byte index, burst counter and synchronizer = 0; last-served = 2.4 GHz.
REQ-032 Reset asserted mid-word SHALL discard the partial word; no pull SHALL be issued in the first cycle after release.

Verification
REQ-033 Only 0.9 GHz non-empty, data 0x44332211, 4 read strobes -> one pull, bytes 0x11, 0x22, 0x33, 0x44, o_smi_chan = 0, then IDLE with read_req = 0.
REQ-034 Both channels always non-empty, BURST_LEN = 4 -> 4 words from 0.9 GHz, 4 from 2.4 GHz, alternating in bursts of 4; never two pulls in one cycle.
REQ-035 2.4 GHz only, 3 words queued, BURST_LEN = 4 -> 3 words served back-to-back with 2-cycle gaps, then IDLE, no 4th pull.
REQ-036 i_chan_en[0] cleared after byte1 of a 0.9 GHz word -> bytes 2 and 3 still served, then IDLE; 0.9 GHz is not pulled again.
REQ-037 i_rst_b pulsed low after byte2 -> all outputs at reset values immediately; after release, a fresh word is pulled from 0.9 GHz starting at byte0.
REQ-038 Read strobe toggled in IDLE with both FIFOs empty -> no pull, no state change, read_req stays 0.
